i2s_tx_clkgen: RTL and testbench

- Consumes the audio PLL's 16.953125 MHz output (outclk_2) and its `locked` flag.
- Generates the I2S bit clock (BCLK) and word clock (LRCK), and serialises stereo PCM samples to the codec DAC.
- Sits between the synth voice mixer (upstream, valid/ready sample stream) and the codec pins.
- Holds its outputs quiet until the PLL has been stably locked.

---
 rtl/audio_pkg.sv | 15 +
 rtl/sync2_bit.sv | 24 ++
 rtl/i2s_tx_clkgen.sv | 171 +++++++++++++++++
 tb/tb_i2s_tx_clkgen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio types, default constants and frame-length helper
package audio_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  localparam int DEF_DATA_W   = 24;
  localparam int DEF_SLOT_W   = 32;
  localparam int DEF_BCLK_DIV = 6;
  localparam int DEF_LOCK_CYC = 1024;

  function automatic int frame_len(input int slot_w);
    return 2 * slot_w;
  endfunction

endpackage

// File: rtl/sync2_bit.sv
// rtl/sync2_bit.sv - two-flop synchroniser for an asynchronous single-bit flag
module sync2_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/i2s_tx_clkgen.sv
// rtl/i2s_tx_clkgen.sv - I2S BCLK/LRCK generator and stereo serialiser gated by PLL lock
// Define LEFT_JUSTIFIED_EN for left-justified framing; standard I2S otherwise.
module i2s_tx_clkgen import audio_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SLOT_W   = DEF_SLOT_W,
  parameter int BCLK_DIV = DEF_BCLK_DIV,
  parameter int LOCK_CYC = DEF_LOCK_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              bclk,
  output logic              lrck,
  output logic              sdata,
  output logic              running,
  output logic              underrun
);

  localparam int FRAME  = frame_len(SLOT_W);
  localparam int HALF   = BCLK_DIV / 2;
  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam int BIT_W  = $clog2(FRAME);
  localparam int LOCK_W = $clog2(LOCK_CYC + 1);

  state_t              r_state;
  logic [LOCK_W-1:0]   r_lock_cnt;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic                r_started;
  logic                r_hold_full;
  logic [DATA_W-1:0]   r_hold_l;
  logic [DATA_W-1:0]   r_hold_r;
  logic [FRAME-1:0]    r_shift;
  logic                r_bclk;
  logic                r_lrck;
  logic                r_sdata;
  logic                r_running;
  logic                r_ready;
  logic                r_underrun;

  logic                w_lock_s;
  logic                w_fe;
  logic                w_load;
  logic                w_xfer;
  logic                w_full_nxt;
  logic [DIV_W-1:0]    w_div_nxt;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic [FRAME-1:0]    w_frame;

  sync2_bit u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pll_locked),
    .o_q   (w_lock_s)
  );

  // The very first FE after RUN entry starts frame 0 without advancing bit_cnt.
  always_comb begin
    w_div_nxt  = (r_div_cnt == DIV_W'(BCLK_DIV - 1)) ? '0 : r_div_cnt + DIV_W'(1);
    w_fe       = (r_state == RUN) && (r_div_cnt == DIV_W'(BCLK_DIV - 1));
    w_load     = w_fe && (!r_started || (r_bit_cnt == BIT_W'(FRAME - 1)));
    w_bit_nxt  = r_bit_cnt;
    if (w_fe) begin
      w_bit_nxt = w_load ? '0 : r_bit_cnt + BIT_W'(1);
    end
    w_xfer     = sample_valid && r_ready;
    w_full_nxt = w_xfer || (r_hold_full && !w_load);
    w_frame    = '0;
    if (r_hold_full) begin
      w_frame[FRAME-1 -: DATA_W]  = r_hold_l;
      w_frame[SLOT_W-1 -: DATA_W] = r_hold_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lock_cnt  <= '0;
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_started   <= 1'b0;
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_shift     <= '0;
      r_bclk      <= 1'b0;
      r_lrck      <= 1'b0;
      r_sdata     <= 1'b0;
      r_running   <= 1'b0;
      r_ready     <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      case (r_state)
        IDLE: begin
          r_lock_cnt <= '0;
          if (w_lock_s) r_state <= SYNC;
        end
        SYNC: begin
          if (!w_lock_s) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
          end else if (r_lock_cnt == LOCK_W'(LOCK_CYC - 1)) begin
            r_state    <= RUN;
            r_lock_cnt <= '0;
            r_running  <= 1'b1;
            r_ready    <= 1'b1;
          end else begin
            r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
          end
        end
        RUN: begin
          if (!w_lock_s) begin
            r_state     <= IDLE;
            r_div_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_started   <= 1'b0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bclk      <= 1'b0;
            r_lrck      <= 1'b0;
            r_sdata     <= 1'b0;
            r_running   <= 1'b0;
            r_ready     <= 1'b0;
          end else begin
            r_div_cnt   <= w_div_nxt;
            r_bclk      <= (w_div_nxt >= DIV_W'(HALF));
            r_bit_cnt   <= w_bit_nxt;
            r_hold_full <= w_full_nxt;
            r_ready     <= !w_full_nxt;
            if (w_xfer) begin
              r_hold_l <= left_in;
              r_hold_r <= right_in;
            end
            if (w_fe) begin
              r_started <= 1'b1;
              r_lrck    <= (w_bit_nxt >= BIT_W'(SLOT_W));
              if (w_load) begin
                r_underrun <= !r_hold_full;
`ifdef LEFT_JUSTIFIED_EN
                r_sdata    <= w_frame[FRAME-1];
                r_shift    <= w_frame << 1;
`else
                // Last bit of the outgoing frame spills into bit_cnt 0 of the new one.
                r_sdata    <= r_shift[FRAME-1];
                r_shift    <= w_frame;
`endif
              end else begin
                r_sdata <= r_shift[FRAME-1];
                r_shift <= r_shift << 1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sample_ready = r_ready;
  assign bclk         = r_bclk;
  assign lrck         = r_lrck;
  assign sdata        = r_sdata;
  assign running      = r_running;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_i2s_tx_clkgen.sv
// tb/tb_i2s_tx_clkgen.sv - self-checking bench for i2s_tx_clkgen against a timeline reference model
module tb_i2s_tx_clkgen;

  logic        clk;
  logic        rst_n;
  logic        pll_locked;
  logic [23:0] left_in;
  logic [23:0] right_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic        running;
  logic        underrun;

  i2s_tx_clkgen #(
    .DATA_W   (24),
    .SLOT_W   (32),
    .BCLK_DIV (6),
    .LOCK_CYC (1024)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .left_in      (left_in),
    .right_in     (right_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrck         (lrck),
    .sdata        (sdata),
    .running      (running),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LEFT_JUSTIFIED_EN
  localparam int OFF = 0;
`else
  localparam int OFF = 1;
`endif

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [63:0] f;
  } vec_t;

  vec_t        tbl [6];
  int          n_pass;
  int          n_total;
  bit          model_on;
  int          cyc_run;
  bit          m_full;
  logic [63:0] m_hold;
  logic [63:0] frames [0:63];
  int          nfr;
  bit          last_xfer;
  int          und_seen;
  logic        cap [0:4095];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: k counts edges since RUN entry; frame n loads at k = 6 + 384*n.
  task automatic tick();
    bit          xfer;
    bit          load;
    bit          und;
    int          k;
    int          q;
    int          b;
    int          sub;
    int          bitn;
    int          n;
    logic [5:0]  e;
    logic [5:0]  a;
    @(posedge clk);
    #1;
    if (model_on) begin
      k = cyc_run;
      cyc_run++;
      xfer = sample_valid && !m_full;
      load = (k >= 6) && ((k - 6) % 384 == 0);
      und  = 1'b0;
      if (load) begin
        frames[nfr] = m_full ? m_hold : 64'd0;
        und = !m_full;
        nfr++;
        m_full = 1'b0;
      end
      if (xfer) begin
        m_hold = {left_in, 8'h00, right_in, 8'h00};
        m_full = 1'b1;
      end
      last_xfer = xfer;
      e = {(k % 6) >= 3, 1'b0, 1'b0, 1'b1, !m_full, und};
      if (k >= 6) begin
        q    = k - 6;
        b    = q / 6;
        sub  = q % 6;
        bitn = b % 64;
        n    = b / 64;
        e[4] = (bitn >= 32);
`ifdef LEFT_JUSTIFIED_EN
        e[3] = frames[n][63 - bitn];
`else
        if (bitn == 0) e[3] = (n == 0) ? 1'b0 : frames[n-1][0];
        else           e[3] = frames[n][64 - bitn];
`endif
        if (sub == 4 && b < 4096) cap[b] = sdata;
      end
      a = {bclk, lrck, sdata, running, sample_ready, underrun};
      check($sformatf("outs k=%0d {bclk,lrck,sdata,run,rdy,und}", k), {58'd0, a}, {58'd0, e});
      if (underrun) und_seen++;
    end
  endtask

  task automatic run_to(input int kk);
    while (cyc_run <= kk) tick();
  endtask

  task automatic wait_running(output int n);
    n = -1;
    for (int i = 1; i <= 3000; i++) begin
      tick();
      if (running) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic start_model();
    model_on = 1'b1;
    cyc_run  = 1;
    m_full   = 1'b0;
    nfr      = 0;
  endtask

  function automatic logic [63:0] cap_frame(input int n);
    logic [63:0] f;
    for (int j = 0; j < 64; j++) f[63-j] = cap[64*n + j + OFF];
    return f;
  endfunction

  task automatic random_frames(input int nframes);
    logic [31:0] t;
    for (int c = 0; c < 384 * nframes; c++) begin
      sample_valid = ((cyc_run / 384) % 4 != 3) && ($urandom % 4 != 0);
      t = $urandom; left_in  = t[23:0];
      t = $urandom; right_in = t[23:0];
      tick();
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    int n;
    int t;
    int target;
    tbl[0] = '{24'hA5A5A5, 24'h800001, 64'hA5A5A500_80000100};
    tbl[1] = '{24'h000000, 24'hFFFFFF, 64'h00000000_FFFFFF00};
    tbl[2] = '{24'h7FFFFF, 24'h800000, 64'h7FFFFF00_80000000};
    tbl[3] = '{24'h123456, 24'hABCDEF, 64'h12345600_ABCDEF00};
    tbl[4] = '{24'hFFFFFF, 24'h000001, 64'hFFFFFF00_00000100};
    tbl[5] = '{24'h5A5A5A, 24'h3C3C3C, 64'h5A5A5A00_3C3C3C00};
    n_pass = 0; n_total = 0; model_on = 1'b0; cyc_run = 0; m_full = 1'b0;
    m_hold = '0; nfr = 0; last_xfer = 1'b0; und_seen = 0;
    for (int i = 0; i < 4096; i++) cap[i] = 1'b0;
    rst_n = 1'b0; pll_locked = 1'b0; sample_valid = 1'b0; left_in = '0; right_in = '0;

    repeat (3) tick();
    check("reset outputs", {58'd0, bclk, lrck, sdata, running, sample_ready, underrun}, 64'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle outputs", {58'd0, bclk, lrck, sdata, running, sample_ready, underrun}, 64'd0);

    // 2 sync edges + IDLE->SYNC edge + 1024 SYNC cycles
    pll_locked = 1'b1;
    wait_running(n);
    check("lock latency", n, 1027);
    start_model();

    for (int i = 0; i < 6; i++) begin
      sample_valid = 1'b1; left_in = tbl[i].l; right_in = tbl[i].r;
      t = 0;
      do begin tick(); t++; end while (!last_xfer && t < 1000);
      check($sformatf("table accept %0d", i), {63'd0, last_xfer}, 64'd1);
    end
    sample_valid = 1'b0; left_in = '0; right_in = '0;

    run_to(6 + 384 * 6 - 1);
    und_seen = 0;
    repeat (384) tick();
    check("underrun pulses in empty frame", und_seen, 1);

    // Handshake lands exactly on the frame-7 load edge: frame 7 stays zero, frame 8 carries it
    sample_valid = 1'b1; left_in = 24'hC00003; right_in = 24'h00FF00;
    tick();
    check("accept on load cycle", {63'd0, last_xfer}, 64'd1);
    sample_valid = 1'b0;
    run_to(6 + 6 * (64 * 9 + 1) + 5);

    for (int i = 0; i < 6; i++)
      check($sformatf("table frame %0d", i), cap_frame(i), tbl[i].f);
    check("underrun frame 6", cap_frame(6), 64'd0);
    check("underrun frame 7", cap_frame(7), 64'd0);
    check("recovery frame 8", cap_frame(8), 64'hC0000300_00FF0000);

    random_frames(16);

    target = 6 + 384 * ((cyc_run - 6) / 384 + 1) + 20 * 6;
    run_to(target);
    pll_locked = 1'b0;
    model_on = 1'b0;
    repeat (2) tick();
    check("running before lock drop lands", {63'd0, running}, 64'd1);
    tick();
    check("outputs quiet after lock loss",
          {58'd0, bclk, lrck, sdata, running, sample_ready, underrun}, 64'd0);

    repeat (10) tick();
    pll_locked = 1'b1;
    repeat (500) tick();
    check("no run during partial lock", {63'd0, running}, 64'd0);
    pll_locked = 1'b0;
    repeat (4) tick();
    pll_locked = 1'b1;
    wait_running(n);
    check("relock latency", n, 1027);
    start_model();
    random_frames(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
